// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
// Optional per-requester grant statistics are enabled by defining ADDER_ARB_STATS_EN.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int STATS_W = 16;
  localparam logic [STATS_W-1:0] STATS_MAX = '1;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin winner search: the first asserted request at or after ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbitrated WIDTH-bit adder: one operation in flight, IDLE -> ADD -> HOLD.
// Define ADDER_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH   = 40,
  parameter int NUM_REQ = 4,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     res_carry,
  output logic [IW-1:0]            res_id,
  output logic [1:0]               dbg_state
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] grant_cnt
`endif
);

  // Handshakes: a transfer happens on a rising clk edge only when valid and
  // ready are both high; valid may drop before ready without any effect.

  state_e               state_q;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        id_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [WIDTH-1:0]     sum_q;
  logic                 carry_q;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [WIDTH-1:0]     a_sel, b_sel;
  logic [NUM_REQ-1:0]   hs_vec;
  logic                 req_hs;
  logic [WIDTH:0]       sum_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // Ready is held low while reset is asserted, even before the state settles.
  assign req_ready = (rst && state_q == IDLE && arb_any) ? arb_grant : '0;
  assign hs_vec    = req_valid & req_ready;
  assign req_hs    = |hs_vec;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_d = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
  assign sum_d = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_hs) begin
            a_q     <= a_sel;
            b_q     <= b_sel;
            id_q    <= arb_idx;
            ptr_q   <= ptr_d;
            state_q <= ADD;
          end
        end
        ADD: begin
          {carry_q, sum_q} <= sum_d;
          state_q          <= HOLD;
        end
        HOLD: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = (state_q == HOLD);
  assign res_sum   = sum_q;
  assign res_carry = carry_q;
  assign res_id    = id_q;
  assign dbg_state = state_q;

`ifdef ADDER_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [STATS_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else if (hs_vec[g] && cnt_q != STATS_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign grant_cnt[g*STATS_W +: STATS_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vectors, multi-cycle corner sequences and a
// randomized phase checked against a transaction-level reference model.
module tb_adder_arbiter;

  localparam int W  = 40;
  localparam int N  = 4;
  localparam int RW = 2 + 1 + W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [W-1:0]     res_sum;
  logic             res_carry;
  logic [1:0]       res_id;
  logic [1:0]       dbg_state;
`ifdef ADDER_ARB_STATS_EN
  logic [N*16-1:0]  grant_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Expected results: {id, carry, sum}
  logic [RW-1:0] exp_q[$];

  adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id),
    .dbg_state (dbg_state)
`ifdef ADDER_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One operation from a single requester, starting and ending in an idle cycle.
  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] sum, input logic carry);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'({$urandom(), $urandom()});
      req_b[i*W +: W] = W'({$urandom(), $urandom()});
    end
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid = N'(1) << id;
    res_ready = 1'b1;
    #1;
    chk("op_ready", req_ready, N'(1) << id);
    chk("op_valid_idle", res_valid, 0);
    tick();
    req_valid = '0;
    #1;
    chk("op_valid_add", res_valid, 0);
    tick();
    chk("op_valid_hold", res_valid, 1);
    chk("op_sum", res_sum, sum);
    chk("op_carry", res_carry, carry);
    chk("op_id", res_id, id);
    tick();
    chk("op_valid_after", res_valid, 0);
  endtask

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 40'd5,             40'd7,             40'd12,            1'b0};
    vecs[1] = '{0, 40'hFF_FFFF_FFFF,  40'd1,             40'd0,             1'b1};
    vecs[2] = '{1, 40'hFF_FFFF_FFFF,  40'hFF_FFFF_FFFF,  40'hFF_FFFF_FFFE,  1'b1};
    vecs[3] = '{2, 40'd0,             40'd0,             40'd0,             1'b0};
    vecs[4] = '{3, 40'h80_0000_0000,  40'h80_0000_0000,  40'd0,             1'b1};
    vecs[5] = '{3, 40'h12_3456_789A,  40'h01_0101_0101,  40'h13_3557_799B,  1'b0};

    // Reset values, with every requester asking during reset
    rst = 1'b0;
    req_valid = '1;
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_carry", res_carry, 0);
    chk("rst_id", res_id, 0);
    req_valid = '0;
    rst = 1'b1;
    tick();

    foreach (vecs[v]) run_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sum, vecs[v].carry);

    // Reset while the operation is in ADD: no result, pointer back to 0
    req_valid = 4'b0010;
    #1;
    chk("rstadd_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    rst = 1'b0;
    #1;
    chk("rstadd_valid", res_valid, 0);
    chk("rstadd_sum", res_sum, 0);
    chk("rstadd_id", res_id, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rstadd_no_result", res_valid, 0);
      tick();
    end

    // All requesters active: grants 0,1,2,3,0 spaced three cycles apart
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i);
      req_b[i*W +: W] = W'(10 * i);
    end
    req_valid = '1;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", req_ready, N'(1) << (k % N));
      tick();
      chk("rr_add_ready", req_ready, 0);
      chk("rr_add_valid", res_valid, 0);
      tick();
      chk("rr_hold_valid", res_valid, 1);
      chk("rr_hold_ready", req_ready, 0);
      chk("rr_sum", res_sum, 11 * (k % N));
      chk("rr_id", res_id, k % N);
      tick();
    end

    // Consumer stalls for five HOLD cycles
    res_ready = 1'b0;
    #1;
    chk("stall_grant", req_ready, 4'b0010);
    tick();
    tick();
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", res_valid, 1);
      chk("stall_sum", res_sum, 11);
      chk("stall_id", res_id, 1);
      chk("stall_ready", req_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("stall_valid_last", res_valid, 1);
    tick();
    chk("stall_regrant", req_ready, 4'b0100);
    req_valid = '0;
    tick();
    chk("drop_no_op", res_valid, 0);
    chk("drop_no_ready", req_ready, 0);

`ifdef ADDER_ARB_STATS_EN
    do_reset();
    for (int r = 0; r < 3; r++) run_op(2, W'(r), W'(1), W'(r + 1), 1'b0);
    chk("stats_cnt", grant_cnt, {16'd0, 16'd3, 16'd0, 16'd0});
`endif

    // Randomized traffic against the transaction-level model
    do_reset();
    exp_q.delete();
    begin
      int m_ptr = 0;
      int m_res_cyc = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        logic [N-1:0] exp_rdy;
        logic         exp_vld;
        int           w;
        for (int i = 0; i < N; i++) begin
          logic [63:0] ra, rb;
          ra = {$urandom(), $urandom()};
          rb = {$urandom(), $urandom()};
          if ($urandom_range(0, 7) == 0) ra = '1;
          if ($urandom_range(0, 7) == 0) rb = '1;
          req_a[i*W +: W] = ra[W-1:0];
          req_b[i*W +: W] = rb[W-1:0];
        end
        req_valid = N'($urandom_range(0, 15));
        res_ready = ($urandom_range(0, 3) != 0);
        #1;
        exp_rdy = '0;
        w = -1;
        if (exp_q.size() == 0) begin
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (w < 0 && req_valid[j]) w = j;
          end
          if (w >= 0) exp_rdy[w] = 1'b1;
        end
        exp_vld = (exp_q.size() != 0) && (cyc >= m_res_cyc);
        chk("rnd_ready", req_ready, exp_rdy);
        chk("rnd_valid", res_valid, exp_vld);
        if (exp_vld) begin
          chk("rnd_sum", res_sum, exp_q[0][W-1:0]);
          chk("rnd_carry", res_carry, exp_q[0][W]);
          chk("rnd_id", res_id, exp_q[0][W+2:W+1]);
        end
        if (exp_vld && res_ready) void'(exp_q.pop_front());
        if (w >= 0) begin
          logic [W:0] s;
          s = {1'b0, req_a[w*W +: W]} + {1'b0, req_b[w*W +: W]};
          exp_q.push_back({2'(w), s});
          m_res_cyc = cyc + 2;
          m_ptr = (w + 1) % N;
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
